parity_protect_tx: RTL and testbench

PARITY_PROTECT_TX -- requirements
Module: parity_protect_tx

---
 rtl/parity_tx_pkg.sv | 38 +++
 rtl/parity_skid_buf.sv | 91 +++++++++
 rtl/parity_protect_tx.sv | 165 ++++++++++++++++
 tb/tb_parity_protect_tx.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/parity_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : parity_tx_pkg
//  Description : Shared types and helpers for the parity-protected transmit
//                path and its receive-side checker.
//  Revision    : 1.0 - initial release
// ============================================================================
package parity_tx_pkg;

  // Widest payload any parity user in the codebase may carry.
  localparam int unsigned MAX_DATA_W  = 64;

  // Status counter widths.
  localparam int unsigned TX_COUNT_W  = 16;
  localparam int unsigned INJ_COUNT_W = 8;

  // Fault-injection controller states.
  typedef enum logic [0:0] {
    INJ_IDLE  = 1'b0,
    INJ_ARMED = 1'b1
  } inj_state_e;

  // Encoding of the inj_mode input.
  typedef enum logic [0:0] {
    INJ_MODE_PARITY = 1'b0,
    INJ_MODE_DATA   = 1'b1
  } inj_mode_e;

  // Parity over a zero-extended payload. Zero extension does not change the
  // XOR reduction, so narrower users cast their data up to MAX_DATA_W.
  // odd = 1 makes the total number of ones (data + parity) odd.
  function automatic logic calc_parity(input logic [MAX_DATA_W-1:0] data,
                                       input logic                  odd);
    return (^data) ^ odd;
  endfunction

endpackage : parity_tx_pkg
`default_nettype wire

// File: rtl/parity_skid_buf.sv
`default_nettype none
// ============================================================================
//  Module      : parity_skid_buf
//  Description : Output register plus one skid entry. Upstream ready is a
//                pure register (no combinational path from m_ready), so the
//                skid entry absorbs the one word that may arrive in the cycle
//                the output stalls.
//  Revision    : 1.0 - initial release
// ============================================================================
module parity_skid_buf #(
  parameter int unsigned WIDTH = 33
) (
  input  logic             clk,
  input  logic             reset,
  // upstream
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  // downstream
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data
);

  logic             out_valid_q,  out_valid_d;
  logic [WIDTH-1:0] out_data_q,   out_data_d;
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] skid_data_q,  skid_data_d;
  logic             ready_q,      ready_d;

  logic             accept;
  logic             out_free;

  assign accept   = s_valid & ready_q;
  // The output register can take a new word when empty or when it drains.
  assign out_free = ~out_valid_q | m_ready;

  // Next-state for the output register and the skid entry; the skid entry
  // always holds the older word, so it refills the output register first.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;

    if (out_free) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        skid_valid_d = accept;
        if (accept) begin
          skid_data_d = s_data;
        end
      end else begin
        out_valid_d = accept;
        if (accept) begin
          out_data_d = s_data;
        end
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_data_d  = s_data;
    end

    // Ready for the next cycle is simply "skid entry will be empty".
    ready_d = ~skid_valid_d;
  end

  // Storage registers; reset empties both entries and holds ready low.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      ready_q      <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      ready_q      <= ready_d;
    end
  end

  assign s_ready = ready_q;
  assign m_valid = out_valid_q;
  assign m_data  = out_data_q;

endmodule : parity_skid_buf
`default_nettype wire

// File: rtl/parity_protect_tx.sv
`default_nettype none
// ============================================================================
//  Module      : parity_protect_tx
//  Description : Attaches a parity bit to each payload word on a valid/ready
//                stream, with a one-shot fault injector that can flip either
//                the parity bit or one data bit of the next accepted word.
//  Revision    : 1.0 - initial release
// ============================================================================
module parity_protect_tx
  import parity_tx_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ODD_PARITY = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  // upstream stream
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [DATA_W-1:0]          s_data,
  // downstream protected stream
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [DATA_W-1:0]          m_data,
  output logic                       m_parity,
  // fault injection control
  input  logic                       inj_req,
  input  logic                       inj_mode,
  input  logic [$clog2(DATA_W)-1:0]  inj_bit,
  output logic                       inj_busy,
  output logic                       inj_done,
  // status
  output logic [TX_COUNT_W-1:0]      tx_count,
  output logic [INJ_COUNT_W-1:0]     inj_count
);

  localparam int unsigned BIT_W = $clog2(DATA_W);
  localparam logic [DATA_W-1:0] ONE_HOT_LSB = {{(DATA_W-1){1'b0}}, 1'b1};

  // --------------------------------------------------------------------------
  // Injection controller
  // --------------------------------------------------------------------------
  inj_state_e              state_q, state_d;
  inj_mode_e               mode_q,  mode_d;
  logic [BIT_W-1:0]        bit_q,   bit_d;

  logic                    s_accept;
  logic                    fire;

  assign s_accept = s_valid & s_ready;

  // Injection FSM register plus the latched mode and bit index.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= INJ_IDLE;
      mode_q  <= INJ_MODE_PARITY;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      bit_q   <= bit_d;
    end
  end

  // Arm on a request while idle; fire on the next accepted word. A request
  // while armed is dropped, and a request alongside an accepted word while
  // idle only arms for the word after it.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    bit_d   = bit_q;
    fire    = 1'b0;

    case (state_q)
      INJ_IDLE: begin
        if (inj_req) begin
          state_d = INJ_ARMED;
          mode_d  = inj_mode_e'(inj_mode);
          bit_d   = inj_bit;
        end
      end
      INJ_ARMED: begin
        if (s_accept) begin
          state_d = INJ_IDLE;
          fire    = 1'b1;
        end
      end
      default: begin
        state_d = INJ_IDLE;
      end
    endcase
  end

  assign inj_busy = (state_q == INJ_ARMED);
  assign inj_done = fire;

  // --------------------------------------------------------------------------
  // Parity generation and corruption
  // --------------------------------------------------------------------------
  logic              clean_parity;
  logic [DATA_W-1:0] data_mask;
  logic              parity_flip;
  logic [DATA_W:0]   buf_in;
  logic [DATA_W:0]   buf_out;

  // Parity is always taken from the clean payload, so a data-bit flip shows
  // up downstream as a parity mismatch.
  assign clean_parity = calc_parity(MAX_DATA_W'(s_data), (ODD_PARITY != 0));

  assign data_mask   = (fire && (mode_q == INJ_MODE_DATA)) ? (ONE_HOT_LSB << bit_q)
                                                           : '0;
  assign parity_flip = fire && (mode_q == INJ_MODE_PARITY);

  assign buf_in = {clean_parity ^ parity_flip, s_data ^ data_mask};

  parity_skid_buf #(
    .WIDTH (DATA_W + 1)
  ) u_skid (
    .clk     (clk),
    .reset   (reset),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (buf_in),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (buf_out)
  );

  assign m_data   = buf_out[DATA_W-1:0];
  assign m_parity = buf_out[DATA_W];

  // --------------------------------------------------------------------------
  // Status counters
  // --------------------------------------------------------------------------
  logic [TX_COUNT_W-1:0]  tx_count_q,  tx_count_d;
  logic [INJ_COUNT_W-1:0] inj_count_q, inj_count_d;

  // Transfer count wraps; injection count saturates at all-ones.
  always_comb begin
    tx_count_d  = tx_count_q;
    inj_count_d = inj_count_q;
    if (m_valid && m_ready) begin
      tx_count_d = tx_count_q + TX_COUNT_W'(1);
    end
    if (fire && (inj_count_q != {INJ_COUNT_W{1'b1}})) begin
      inj_count_d = inj_count_q + INJ_COUNT_W'(1);
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_count_q  <= '0;
      inj_count_q <= '0;
    end else begin
      tx_count_q  <= tx_count_d;
      inj_count_q <= inj_count_d;
    end
  end

  assign tx_count  = tx_count_q;
  assign inj_count = inj_count_q;

endmodule : parity_protect_tx
`default_nettype wire

// File: tb/tb_parity_protect_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_parity_protect_tx
//  Description : Self-checking bench for parity_protect_tx (DATA_W=32, even
//                parity): vector table, scoreboard, and corner sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_parity_protect_tx;
  import parity_tx_pkg::*;

  localparam int unsigned DATA_W = 32;

  logic        clk       = 1'b0;
  logic        reset     = 1'b1;
  logic        s_valid   = 1'b0;
  logic        s_ready;
  logic [31:0] s_data    = '0;
  logic        m_valid;
  logic        m_ready   = 1'b1;
  logic [31:0] m_data;
  logic        m_parity;
  logic        inj_req   = 1'b0;
  logic        inj_mode  = 1'b0;
  logic [4:0]  inj_bit   = '0;
  logic        inj_busy;
  logic        inj_done;
  logic [15:0] tx_count;
  logic [7:0]  inj_count;

  parity_protect_tx #(
    .DATA_W     (DATA_W),
    .ODD_PARITY (0)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_parity  (m_parity),
    .inj_req   (inj_req),
    .inj_mode  (inj_mode),
    .inj_bit   (inj_bit),
    .inj_busy  (inj_busy),
    .inj_done  (inj_done),
    .tx_count  (tx_count),
    .inj_count (inj_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // --------------------------------------------------------------------------
  // Scoreboard and reference model (evaluated mid-cycle on the falling edge)
  // --------------------------------------------------------------------------
  typedef struct {
    logic [31:0] d;
    logic        p;
  } exp_t;

  exp_t        sb[$];
  logic        mdl_armed  = 1'b0;
  logic        mdl_mode   = 1'b0;
  logic [4:0]  mdl_bit    = '0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_d     = '0;
  logic        prev_p     = 1'b0;
  int          chk_flags  = 0;

  always @(negedge clk) begin : monitor
    exp_t        e;
    exp_t        got;
    logic        acc;
    logic        fire;
    logic [31:0] mask;
    if (reset) begin
      sb.delete();
      mdl_armed  = 1'b0;
      prev_stall = 1'b0;
    end else begin
      acc  = s_valid && s_ready;
      fire = mdl_armed && acc;
      check("inj_busy", 64'(inj_busy), 64'(mdl_armed));
      check("inj_done", 64'(inj_done), 64'(fire));

      if (acc) begin
        e.d = s_data;
        e.p = ^s_data;
        if (fire) begin
          if (mdl_mode) begin
            mask = 32'd1;
            e.d  = e.d ^ (mask << mdl_bit);
          end else begin
            e.p = ~e.p;
          end
        end
        sb.push_back(e);
      end

      if (fire) begin
        mdl_armed = 1'b0;
      end else if (!mdl_armed && inj_req) begin
        mdl_armed = 1'b1;
        mdl_mode  = inj_mode;
        mdl_bit   = inj_bit;
      end

      if (prev_stall) begin
        check("hold_valid",  64'(m_valid),  64'(1));
        check("hold_data",   64'(m_data),   64'(prev_d));
        check("hold_parity", 64'(m_parity), 64'(prev_p));
      end

      if (m_valid && m_ready) begin
        check("word_expected", 64'(sb.size() != 0), 64'(1));
        if (sb.size() != 0) begin
          got = sb.pop_front();
          check("sb_data",   64'(m_data),   64'(got.d));
          check("sb_parity", 64'(m_parity), 64'(got.p));
        end
        // Receive-side checker built on the shared parity helper.
        if (calc_parity(64'(m_data), 1'b0) != m_parity) begin
          chk_flags++;
        end
      end

      prev_stall = m_valid && !m_ready;
      prev_d     = m_data;
      prev_p     = m_parity;
    end
  end

  // --------------------------------------------------------------------------
  // Helpers
  // --------------------------------------------------------------------------
  task automatic wait_ready();
    int n = 0;
    while (!s_ready && n < 20) begin
      step();
      n++;
    end
    check("ready_wait", 64'(s_ready), 64'(1));
  endtask

  task automatic send_word(input logic [31:0] d);
    s_valid = 1'b1;
    s_data  = d;
    wait_ready();
    step();
    s_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((sb.size() != 0 || m_valid) && n < 64) begin
      step();
      n++;
    end
    check("drain", 64'(sb.size() == 0 && !m_valid), 64'(1));
  endtask

  task automatic pulse_inj(input logic mode, input logic [4:0] b);
    inj_req  = 1'b1;
    inj_mode = mode;
    inj_bit  = b;
    step();
    inj_req  = 1'b0;
  endtask

  initial begin : watchdog
    #(10 * 95000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  typedef struct {
    logic [31:0] din;
    logic        inj;
    logic        mode;
    logic [4:0]  bitn;
    logic [31:0] exp_d;
    logic        exp_p;
  } vec_t;

  vec_t vecs[9];

  initial begin : stim
    int   k;
    int   guard;
    int   f0;
    int   i0;
    int   n;
    logic acc;

    vecs[0] = '{32'h0000_0000, 1'b0, 1'b0, 5'd0,  32'h0000_0000, 1'b0};
    vecs[1] = '{32'h0000_0001, 1'b0, 1'b0, 5'd0,  32'h0000_0001, 1'b1};
    vecs[2] = '{32'hFFFF_FFFF, 1'b0, 1'b0, 5'd0,  32'hFFFF_FFFF, 1'b0};
    vecs[3] = '{32'h8000_0001, 1'b0, 1'b0, 5'd0,  32'h8000_0001, 1'b0};
    vecs[4] = '{32'h0000_0003, 1'b1, 1'b0, 5'd0,  32'h0000_0003, 1'b1};
    vecs[5] = '{32'h0000_0000, 1'b1, 1'b1, 5'd5,  32'h0000_0020, 1'b0};
    vecs[6] = '{32'h0000_0007, 1'b0, 1'b0, 5'd0,  32'h0000_0007, 1'b1};
    vecs[7] = '{32'hA5A5_A5A5, 1'b1, 1'b1, 5'd31, 32'h25A5_A5A5, 1'b0};
    vecs[8] = '{32'h1234_5678, 1'b0, 1'b0, 5'd0,  32'h1234_5678, 1'b1};

    // ---- reset state ----
    reset = 1'b1;
    repeat (3) step();
    check("rst_m_valid",   64'(m_valid),   64'(0));
    check("rst_s_ready",   64'(s_ready),   64'(0));
    check("rst_m_data",    64'(m_data),    64'(0));
    check("rst_m_parity",  64'(m_parity),  64'(0));
    check("rst_inj_busy",  64'(inj_busy),  64'(0));
    check("rst_inj_done",  64'(inj_done),  64'(0));
    check("rst_tx_count",  64'(tx_count),  64'(0));
    check("rst_inj_count", 64'(inj_count), 64'(0));
    reset = 1'b0;
    step();
    check("s_ready_after_reset", 64'(s_ready), 64'(1));

    // ---- vector table: one word at a time, output at N+1 ----
    for (int i = 0; i < 9; i++) begin
      f0 = chk_flags;
      if (vecs[i].inj) begin
        pulse_inj(vecs[i].mode, vecs[i].bitn);
        check("vec_armed", 64'(inj_busy), 64'(1));
      end
      send_word(vecs[i].din);
      check("vec_m_valid",  64'(m_valid),  64'(1));
      check("vec_m_data",   64'(m_data),   64'(vecs[i].exp_d));
      check("vec_m_parity", 64'(m_parity), 64'(vecs[i].exp_p));
      step();
      check("vec_tx_count", 64'(tx_count), 64'(i + 1));
      check("vec_checker_flag", 64'(chk_flags - f0),
            64'((^vecs[i].exp_d) ^ vecs[i].exp_p));
    end
    check("vec_inj_count", 64'(inj_count), 64'(3));

    // ---- backpressure: 5 stalled cycles while streaming ----
    m_ready = 1'b0;
    s_valid = 1'b1;
    k       = 0;
    s_data  = 32'hC0DE_0000;
    repeat (5) begin
      acc = s_valid && s_ready;
      step();
      if (acc) begin
        k++;
        s_data = 32'hC0DE_0000 + 32'(k);
      end
    end
    check("bp_accepted",  64'(k),       64'(2));
    check("bp_s_ready",   64'(s_ready), 64'(0));
    check("bp_m_valid",   64'(m_valid), 64'(1));
    check("bp_held_data", 64'(m_data),  64'(32'hC0DE_0000));
    m_ready = 1'b1;
    guard   = 0;
    while (k < 8 && guard < 50) begin
      acc = s_valid && s_ready;
      step();
      guard++;
      if (acc) begin
        k++;
        s_data = 32'hC0DE_0000 + 32'(k);
      end
      if (k == 8) s_valid = 1'b0;
    end
    s_valid = 1'b0;
    check("bp_total", 64'(k), 64'(8));
    wait_drain();

    // ---- sustained throughput ----
    s_valid = 1'b1;
    n       = 0;
    for (int c = 0; c < 16; c++) begin
      s_data = $urandom;
      acc    = s_valid && s_ready;
      step();
      if (acc) n++;
    end
    s_valid = 1'b0;
    check("throughput", 64'(n), 64'(16));
    wait_drain();

    // ---- repeated inj_req while armed: one corruption only ----
    i0 = inj_count;
    f0 = chk_flags;
    inj_req  = 1'b1;
    inj_mode = 1'b0;
    step();
    inj_mode = 1'b1;
    inj_bit  = 5'd3;
    step();
    inj_req  = 1'b0;
    check("rep_busy", 64'(inj_busy), 64'(1));
    send_word(32'h0000_0000);
    check("rep_first_parity", 64'(m_parity), 64'(1));
    check("rep_first_data",   64'(m_data),   64'(0));
    send_word(32'h0000_0000);
    check("rep_second_parity", 64'(m_parity), 64'(0));
    wait_drain();
    check("rep_inj_count", 64'(inj_count), 64'(i0 + 1));
    check("rep_flags",     64'(chk_flags - f0), 64'(1));

    // ---- inj_req together with an accepted word arms the next one ----
    i0 = inj_count;
    wait_ready();
    s_valid  = 1'b1;
    s_data   = 32'h0000_0011;
    inj_req  = 1'b1;
    inj_mode = 1'b1;
    inj_bit  = 5'd0;
    step();
    inj_req  = 1'b0;
    check("same_busy",  64'(inj_busy), 64'(1));
    check("same_clean", 64'(m_data),   64'(32'h0000_0011));
    wait_ready();
    step();
    s_valid = 1'b0;
    check("same_next_corrupt", 64'(m_data), 64'(32'h0000_0010));
    wait_drain();
    check("same_inj_count", 64'(inj_count), 64'(i0 + 1));

    // ---- tx_count wrap after 65536 transfers ----
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    step();
    m_ready = 1'b1;
    s_valid = 1'b1;
    n       = 0;
    guard   = 0;
    while (n < 65535 && guard < 70000) begin
      s_data = $urandom;
      acc    = s_valid && s_ready;
      step();
      guard++;
      if (acc) n++;
    end
    s_valid = 1'b0;
    wait_drain();
    check("wrap_ffff", 64'(tx_count), 64'(16'hFFFF));
    send_word($urandom);
    wait_drain();
    check("wrap_zero", 64'(tx_count), 64'(0));

    // ---- inj_count saturation after 300 injections ----
    for (int j = 0; j < 300; j++) begin
      pulse_inj(1'b0, 5'd0);
      send_word($urandom);
      if (j == 254) begin
        step();
        check("sat_255", 64'(inj_count), 64'(8'hFF));
      end
    end
    wait_drain();
    check("sat_final", 64'(inj_count), 64'(8'hFF));

    // ---- reset with two words buffered and injection armed ----
    m_ready = 1'b0;
    send_word(32'hDEAD_0001);
    send_word(32'hDEAD_0002);
    pulse_inj(1'b0, 5'd0);
    check("mid_busy",    64'(inj_busy), 64'(1));
    check("mid_s_ready", 64'(s_ready),  64'(0));
    check("mid_m_valid", 64'(m_valid),  64'(1));
    reset = 1'b1;
    step();
    check("mid_rst_m_valid",  64'(m_valid),  64'(0));
    check("mid_rst_inj_busy", 64'(inj_busy), 64'(0));
    check("mid_rst_m_data",   64'(m_data),   64'(0));
    reset   = 1'b0;
    m_ready = 1'b1;
    repeat (6) step();
    check("mid_no_stale",  64'(m_valid),  64'(0));
    check("mid_tx_count",  64'(tx_count), 64'(0));
    check("mid_idle_busy", 64'(inj_busy), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_parity_protect_tx
`default_nettype wire
